// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch controller.
// Holds the FSM state enum, default widths and a count-width helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RUN,
    PAUSED
  } sw_state_t;

  localparam int SW_W         = 8;
  localparam int SW_LAP_DEPTH = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Bundle between front-panel logic, stoptimer and the controller.
// master: button/timer/lap-reader side; slave: stopwatch_ctrl.
interface stopwatch_ctrl_if
  import stopwatch_pkg::*;
#(
  parameter int W         = SW_W,
  parameter int LAP_DEPTH = SW_LAP_DEPTH
);

  localparam int CW = cnt_w(LAP_DEPTH);

  logic          btn_ss;
  logic          btn_lap;
  logic [W-1:0]  elapsed_time;
  logic          tmr_start;
  logic          tmr_stop;
  logic          tmr_rst;
  logic          running;
  logic          lap_rd;
  logic [W-1:0]  lap_data;
  logic          lap_valid;
  logic [CW-1:0] lap_count;
  logic          lap_ovf;

  modport master (
    output btn_ss, btn_lap, elapsed_time, lap_rd,
    input  tmr_start, tmr_stop, tmr_rst, running,
    input  lap_data, lap_valid, lap_count, lap_ovf
  );

  modport slave (
    input  btn_ss, btn_lap, elapsed_time, lap_rd,
    output tmr_start, tmr_stop, tmr_rst, running,
    output lap_data, lap_valid, lap_count, lap_ovf
  );

endinterface

// File: rtl/lap_fifo.sv
// Show-ahead lap FIFO with sticky overflow and synchronous flush.
// Ports: push/pop/flush, din, head (0 when empty), count, full, empty, ovf.
module lap_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          push_en;
  logic          pop_en;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // A push that finds the FIFO full is dropped even if a pop
  // happens in the same cycle; a pop on empty is ignored.
  assign push_en = push & ~full & ~flush;
  assign pop_en  = pop & ~empty & ~flush;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push_en) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + 1'b1;
      end
      if (pop_en) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(push_en) - CW'(pop_en);
      if (push && full) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign head  = empty ? '0 : mem_q[rd_q];
  assign count = cnt_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: turns btn_ss/btn_lap pulses into registered
// start/stop/rst strobes for stoptimer and captures laps into lap_fifo.
// Ports: clk, rst_n (async, active-low), sw (stopwatch_ctrl_if.slave).
// Option: STOPWATCH_AUTO_STOP_EN stops the timer at all-ones count.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int W         = SW_W,
  parameter int LAP_DEPTH = SW_LAP_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  stopwatch_ctrl_if.slave sw
);

  sw_state_t state_q, state_d;
  logic      start_q, start_d;
  logic      stop_q, stop_d;
  logic      trst_q, trst_d;
  logic      run_q, run_d;
  logic      push;
  logic      flush;
  logic      full;
  logic      empty;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    trst_d  = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      INIT: begin
        trst_d  = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        if (sw.btn_ss) begin
          start_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Lap and stop are independent here; both may fire.
        push = sw.btn_lap;
        if (sw.btn_ss) begin
          stop_d  = 1'b1;
          state_d = PAUSED;
        end
`ifdef STOPWATCH_AUTO_STOP_EN
        else if (sw.elapsed_time == '1) begin
          stop_d  = 1'b1;
          state_d = PAUSED;
        end
`endif
      end
      PAUSED: begin
        // Restart has priority; a coincident clear is dropped.
        if (sw.btn_ss) begin
          start_d = 1'b1;
          state_d = RUN;
        end else if (sw.btn_lap) begin
          trst_d  = 1'b1;
          flush   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      trst_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      trst_q  <= trst_d;
      run_q   <= run_d;
    end
  end

  assign sw.tmr_start = start_q;
  assign sw.tmr_stop  = stop_q;
  assign sw.tmr_rst   = trst_q;
  assign sw.running   = run_q;

  lap_fifo #(
    .W     (W),
    .DEPTH (LAP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (sw.lap_rd),
    .flush (flush),
    .din   (sw.elapsed_time),
    .head  (sw.lap_data),
    .count (sw.lap_count),
    .full  (full),
    .empty (empty),
    .ovf   (sw.lap_ovf)
  );

  assign sw.lap_valid = ~empty;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with hand-computed expectations.
// Covers reset, start/stop, laps, overflow/clear, coincident buttons.
module tb_stopwatch_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  stopwatch_ctrl_if #(.W(8), .LAP_DEPTH(4)) sw ();

  stopwatch_ctrl #(.W(8), .LAP_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (sw.tmr_rst !== 1'b0) begin miscompares++; $display("FAIL rst_trst got=%b exp=0", sw.tmr_rst); end
    vectors++; if (sw.tmr_start !== 1'b0) begin miscompares++; $display("FAIL rst_start got=%b exp=0", sw.tmr_start); end
    vectors++; if (sw.running !== 1'b0) begin miscompares++; $display("FAIL rst_running got=%b exp=0", sw.running); end
    vectors++; if (sw.lap_count !== 3'd0) begin miscompares++; $display("FAIL rst_count got=%0d exp=0", sw.lap_count); end
    vectors++; if (sw.lap_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", sw.lap_valid); end
    vectors++; if (sw.lap_data !== 8'd0) begin miscompares++; $display("FAIL rst_data got=%0d exp=0", sw.lap_data); end
    vectors++; if (sw.lap_ovf !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got=%b exp=0", sw.lap_ovf); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    vectors++; if (sw.tmr_rst !== 1'b1) begin miscompares++; $display("FAIL init_trst got=%b exp=1", sw.tmr_rst); end
    cyc();
    vectors++; if (sw.tmr_rst !== 1'b0) begin miscompares++; $display("FAIL init_trst_once got=%b exp=0", sw.tmr_rst); end
    vectors++; if (sw.running !== 1'b0) begin miscompares++; $display("FAIL idle_running got=%b exp=0", sw.running); end
    vectors++; if (sw.lap_count !== 3'd0) begin miscompares++; $display("FAIL idle_count got=%0d exp=0", sw.lap_count); end
  endtask

  task automatic test_start_stop();
    sw.btn_ss = 1'b1; cyc(); sw.btn_ss = 1'b0;
    vectors++; if (sw.tmr_start !== 1'b1) begin miscompares++; $display("FAIL ss_start got=%b exp=1", sw.tmr_start); end
    vectors++; if (sw.running !== 1'b1) begin miscompares++; $display("FAIL ss_running got=%b exp=1", sw.running); end
    vectors++; if (sw.tmr_stop !== 1'b0) begin miscompares++; $display("FAIL ss_nostop got=%b exp=0", sw.tmr_stop); end
    cyc();
    vectors++; if (sw.tmr_start !== 1'b0) begin miscompares++; $display("FAIL ss_start_once got=%b exp=0", sw.tmr_start); end
    repeat (3) cyc();
    sw.btn_ss = 1'b1; cyc(); sw.btn_ss = 1'b0;
    vectors++; if (sw.tmr_stop !== 1'b1) begin miscompares++; $display("FAIL ss_stop got=%b exp=1", sw.tmr_stop); end
    vectors++; if (sw.running !== 1'b0) begin miscompares++; $display("FAIL ss_paused got=%b exp=0", sw.running); end
    cyc();
    vectors++; if (sw.tmr_stop !== 1'b0) begin miscompares++; $display("FAIL ss_stop_once got=%b exp=0", sw.tmr_stop); end
    sw.btn_ss = 1'b1; cyc(); sw.btn_ss = 1'b0;
    vectors++; if (sw.tmr_start !== 1'b1) begin miscompares++; $display("FAIL ss_restart got=%b exp=1", sw.tmr_start); end
    vectors++; if (sw.running !== 1'b1) begin miscompares++; $display("FAIL ss_rerun got=%b exp=1", sw.running); end
  endtask

  task automatic test_laps();
    sw.btn_lap = 1'b1;
    sw.elapsed_time = 8'd3; cyc();
    vectors++; if (sw.lap_data !== 8'd3) begin miscompares++; $display("FAIL lap_first got=%0d exp=3", sw.lap_data); end
    vectors++; if (sw.lap_valid !== 1'b1) begin miscompares++; $display("FAIL lap_valid got=%b exp=1", sw.lap_valid); end
    sw.elapsed_time = 8'd7; cyc();
    sw.elapsed_time = 8'd12; cyc();
    sw.btn_lap = 1'b0;
    vectors++; if (sw.lap_count !== 3'd3) begin miscompares++; $display("FAIL lap_cnt3 got=%0d exp=3", sw.lap_count); end
    vectors++; if (sw.lap_data !== 8'd3) begin miscompares++; $display("FAIL lap_head got=%0d exp=3", sw.lap_data); end
    sw.lap_rd = 1'b1; cyc();
    vectors++; if (sw.lap_data !== 8'd7) begin miscompares++; $display("FAIL pop1 got=%0d exp=7", sw.lap_data); end
    vectors++; if (sw.lap_count !== 3'd2) begin miscompares++; $display("FAIL pop1_cnt got=%0d exp=2", sw.lap_count); end
    cyc();
    vectors++; if (sw.lap_data !== 8'd12) begin miscompares++; $display("FAIL pop2 got=%0d exp=12", sw.lap_data); end
    cyc();
    vectors++; if (sw.lap_valid !== 1'b0) begin miscompares++; $display("FAIL pop3_valid got=%b exp=0", sw.lap_valid); end
    vectors++; if (sw.lap_data !== 8'd0) begin miscompares++; $display("FAIL pop3_data got=%0d exp=0", sw.lap_data); end
    cyc();
    vectors++; if (sw.lap_count !== 3'd0) begin miscompares++; $display("FAIL pop_empty got=%0d exp=0", sw.lap_count); end
    sw.lap_rd = 1'b0;
    sw.btn_lap = 1'b1; sw.elapsed_time = 8'd20; cyc();
    sw.lap_rd = 1'b1; sw.elapsed_time = 8'd21; cyc();
    sw.btn_lap = 1'b0;
    vectors++; if (sw.lap_count !== 3'd1) begin miscompares++; $display("FAIL pushpop_cnt got=%0d exp=1", sw.lap_count); end
    vectors++; if (sw.lap_data !== 8'd21) begin miscompares++; $display("FAIL pushpop_data got=%0d exp=21", sw.lap_data); end
    cyc();
    sw.btn_lap = 1'b1; sw.elapsed_time = 8'd30; cyc();
    sw.btn_lap = 1'b0; sw.lap_rd = 1'b0;
    vectors++; if (sw.lap_count !== 3'd1) begin miscompares++; $display("FAIL pushpop_empty_cnt got=%0d exp=1", sw.lap_count); end
    vectors++; if (sw.lap_data !== 8'd30) begin miscompares++; $display("FAIL pushpop_empty_data got=%0d exp=30", sw.lap_data); end
    sw.lap_rd = 1'b1; cyc(); sw.lap_rd = 1'b0;
    vectors++; if (sw.lap_count !== 3'd0) begin miscompares++; $display("FAIL drain got=%0d exp=0", sw.lap_count); end
  endtask

  task automatic test_overflow();
    sw.btn_lap = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sw.elapsed_time = 8'(i); cyc();
    end
    vectors++; if (sw.lap_count !== 3'd4) begin miscompares++; $display("FAIL ovf_cnt4 got=%0d exp=4", sw.lap_count); end
    vectors++; if (sw.lap_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_pre got=%b exp=0", sw.lap_ovf); end
    sw.elapsed_time = 8'd5; cyc();
    sw.btn_lap = 1'b0;
    vectors++; if (sw.lap_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set got=%b exp=1", sw.lap_ovf); end
    vectors++; if (sw.lap_count !== 3'd4) begin miscompares++; $display("FAIL ovf_cnt got=%0d exp=4", sw.lap_count); end
    vectors++; if (sw.lap_data !== 8'd1) begin miscompares++; $display("FAIL ovf_head got=%0d exp=1", sw.lap_data); end
    sw.btn_ss = 1'b1; cyc(); sw.btn_ss = 1'b0;
    vectors++; if (sw.tmr_stop !== 1'b1) begin miscompares++; $display("FAIL ovf_stop got=%b exp=1", sw.tmr_stop); end
    sw.btn_lap = 1'b1; cyc(); sw.btn_lap = 1'b0;
    vectors++; if (sw.tmr_rst !== 1'b1) begin miscompares++; $display("FAIL clr_trst got=%b exp=1", sw.tmr_rst); end
    vectors++; if (sw.lap_count !== 3'd0) begin miscompares++; $display("FAIL clr_cnt got=%0d exp=0", sw.lap_count); end
    vectors++; if (sw.lap_ovf !== 1'b0) begin miscompares++; $display("FAIL clr_ovf got=%b exp=0", sw.lap_ovf); end
    vectors++; if (sw.running !== 1'b0) begin miscompares++; $display("FAIL clr_running got=%b exp=0", sw.running); end
    sw.btn_lap = 1'b1; sw.elapsed_time = 8'd44; cyc(); sw.btn_lap = 1'b0;
    vectors++; if (sw.lap_count !== 3'd0) begin miscompares++; $display("FAIL idle_lap_cnt got=%0d exp=0", sw.lap_count); end
    vectors++; if (sw.tmr_rst !== 1'b0) begin miscompares++; $display("FAIL idle_lap_trst got=%b exp=0", sw.tmr_rst); end
    vectors++; if (sw.running !== 1'b0) begin miscompares++; $display("FAIL idle_lap_running got=%b exp=0", sw.running); end
  endtask

  task automatic test_simultaneous();
    sw.btn_ss = 1'b1; cyc(); sw.btn_ss = 1'b0;
    vectors++; if (sw.tmr_start !== 1'b1) begin miscompares++; $display("FAIL sim_start got=%b exp=1", sw.tmr_start); end
    sw.btn_ss = 1'b1; sw.btn_lap = 1'b1; sw.elapsed_time = 8'd9; cyc();
    vectors++; if (sw.tmr_stop !== 1'b1) begin miscompares++; $display("FAIL run_both_stop got=%b exp=1", sw.tmr_stop); end
    vectors++; if (sw.lap_data !== 8'd9) begin miscompares++; $display("FAIL run_both_lap got=%0d exp=9", sw.lap_data); end
    vectors++; if (sw.lap_count !== 3'd1) begin miscompares++; $display("FAIL run_both_cnt got=%0d exp=1", sw.lap_count); end
    vectors++; if (sw.running !== 1'b0) begin miscompares++; $display("FAIL run_both_running got=%b exp=0", sw.running); end
    sw.elapsed_time = 8'd10; cyc();
    sw.btn_ss = 1'b0; sw.btn_lap = 1'b0;
    vectors++; if (sw.tmr_start !== 1'b1) begin miscompares++; $display("FAIL pause_both_start got=%b exp=1", sw.tmr_start); end
    vectors++; if (sw.tmr_rst !== 1'b0) begin miscompares++; $display("FAIL pause_both_trst got=%b exp=0", sw.tmr_rst); end
    vectors++; if (sw.tmr_stop !== 1'b0) begin miscompares++; $display("FAIL pause_both_stop got=%b exp=0", sw.tmr_stop); end
    vectors++; if (sw.lap_count !== 3'd1) begin miscompares++; $display("FAIL pause_both_cnt got=%0d exp=1", sw.lap_count); end
    vectors++; if (sw.lap_data !== 8'd9) begin miscompares++; $display("FAIL pause_both_data got=%0d exp=9", sw.lap_data); end
    vectors++; if (sw.running !== 1'b1) begin miscompares++; $display("FAIL pause_both_running got=%b exp=1", sw.running); end
  endtask

  task automatic test_auto_stop();
    sw.elapsed_time = 8'd255; cyc();
    sw.elapsed_time = 8'd0;
`ifdef STOPWATCH_AUTO_STOP_EN
    vectors++; if (sw.tmr_stop !== 1'b1) begin miscompares++; $display("FAIL auto_stop got=%b exp=1", sw.tmr_stop); end
    vectors++; if (sw.running !== 1'b0) begin miscompares++; $display("FAIL auto_paused got=%b exp=0", sw.running); end
    cyc();
    vectors++; if (sw.running !== 1'b0) begin miscompares++; $display("FAIL auto_hold got=%b exp=0", sw.running); end
    sw.btn_ss = 1'b1; cyc(); sw.btn_ss = 1'b0;
    vectors++; if (sw.tmr_start !== 1'b1) begin miscompares++; $display("FAIL auto_restart got=%b exp=1", sw.tmr_start); end
`else
    vectors++; if (sw.tmr_stop !== 1'b0) begin miscompares++; $display("FAIL wrap_nostop got=%b exp=0", sw.tmr_stop); end
    vectors++; if (sw.running !== 1'b1) begin miscompares++; $display("FAIL wrap_running got=%b exp=1", sw.running); end
    cyc();
    vectors++; if (sw.running !== 1'b1) begin miscompares++; $display("FAIL wrap_hold got=%b exp=1", sw.running); end
`endif
  endtask

  task automatic test_reset_mid_run();
    sw.btn_lap = 1'b1; sw.elapsed_time = 8'd5; cyc(); sw.btn_lap = 1'b0;
    vectors++; if (sw.lap_count !== 3'd2) begin miscompares++; $display("FAIL mid_cnt got=%0d exp=2", sw.lap_count); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (sw.running !== 1'b0) begin miscompares++; $display("FAIL mid_running got=%b exp=0", sw.running); end
    vectors++; if (sw.lap_count !== 3'd0) begin miscompares++; $display("FAIL mid_flush got=%0d exp=0", sw.lap_count); end
    vectors++; if (sw.lap_data !== 8'd0) begin miscompares++; $display("FAIL mid_data got=%0d exp=0", sw.lap_data); end
    @(negedge clk) rst_n = 1'b1;
    cyc();
    vectors++; if (sw.tmr_rst !== 1'b1) begin miscompares++; $display("FAIL mid_trst got=%b exp=1", sw.tmr_rst); end
    cyc();
    vectors++; if (sw.tmr_rst !== 1'b0) begin miscompares++; $display("FAIL mid_trst_once got=%b exp=0", sw.tmr_rst); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    sw.btn_ss = 1'b0;
    sw.btn_lap = 1'b0;
    sw.lap_rd = 1'b0;
    sw.elapsed_time = 8'd0;
    test_reset();
    test_start_stop();
    test_laps();
    test_overflow();
    test_simultaneous();
    test_auto_stop();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
